// File: rtl/ofdm_qam_mapper.sv
// OFDM bit-to-constellation mapper: gearboxes IN_W-bit beats through an 8-bit
// accumulator and emits Gray-mapped BPSK / QPSK / 16-QAM points scaled to unit average power.
module ofdm_qam_mapper #(
    parameter int IN_W = 2,   // 1, 2 or 4
    parameter int IQ_W = 16
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [IN_W-1:0]     DAT_I,
    input  logic                CYC_I,
    input  logic                STB_I,
    input  logic                WE_I,
    output logic                ACK_O,
    input  logic [1:0]          MOD,
    output logic [2*IQ_W-1:0]   DAT_O,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    input  logic                ACK_I,
    output logic [1:0]          fsm_state
);

    // Handshake: a beat transfers on a rising edge where STB and ACK are both high.
    // ACK_O is combinational from registered state; STB_O/DAT_O stay put until ACK_I.
    // fsm_state encoding: 0=IDLE, 1=RUN, 2=FLUSH, 3=CLOSE.

    function automatic longint round_sqrt(longint num, longint den);
        longint r;
        longint t;
        r = 0;
        for (int b = IQ_W - 2; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t * den <= num) r = t;
        end
        // round to nearest: sqrt(num/den) >= r + 0.5  <=>  4*num >= den*(2r+1)^2
        if (4 * num >= den * (2 * r + 1) * (2 * r + 1)) r = r + 1;
        return r;
    endfunction

    localparam longint A_L    = longint'(1) << (IQ_W - 2);
    localparam longint QPSK_L = round_sqrt(A_L * A_L, 2);
    localparam longint Q1_L   = round_sqrt(A_L * A_L, 10);
    localparam longint Q3_L   = round_sqrt(9 * A_L * A_L, 10);

    localparam logic signed [IQ_W-1:0] P_A  = IQ_W'(A_L);
    localparam logic signed [IQ_W-1:0] N_A  = -P_A;
    localparam logic signed [IQ_W-1:0] P_QP = IQ_W'(QPSK_L);
    localparam logic signed [IQ_W-1:0] N_QP = -P_QP;
    localparam logic signed [IQ_W-1:0] P_Q1 = IQ_W'(Q1_L);
    localparam logic signed [IQ_W-1:0] N_Q1 = -P_Q1;
    localparam logic signed [IQ_W-1:0] P_Q3 = IQ_W'(Q3_L);
    localparam logic signed [IQ_W-1:0] N_Q3 = -P_Q3;

    localparam logic [3:0] IN_W4 = 4'(IN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        CLOSE = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  mod_q;
    logic [7:0]  acc;
    logic [3:0]  fill;

    logic [3:0]  k;
    logic [3:0]  take;
    logic        has_sym;
    logic        emit;
    logic        accept;
    logic [3:0]  fill_after;
    logic [3:0]  fill_next;
    logic [7:0]  acc_after;
    logic [7:0]  acc_next;
    logic [7:0]  din8;
    logic [3:0]  sym;
    logic signed [IQ_W-1:0] map_i;
    logic signed [IQ_W-1:0] map_q;

    // Gray pair, first bit selects sign, second bit selects inner/outer ring.
    function automatic logic signed [IQ_W-1:0] qam_lvl(input logic first, input logic second);
        logic signed [IQ_W-1:0] v;
        case ({first, second})
            2'b00:   v = N_Q3;
            2'b01:   v = N_Q1;
            2'b11:   v = P_Q1;
            default: v = P_Q3;
        endcase
        return v;
    endfunction

    assign fsm_state = state;
    assign WE_O      = STB_O;
    assign din8      = {{(8 - IN_W){1'b0}}, DAT_I};

    assign ACK_O = !RST_I && CYC_I && STB_I && WE_I
                 && (({1'b0, fill} + {1'b0, IN_W4}) <= 5'd8)
                 && ((state == IDLE) || (state == RUN));

    always_comb begin
        k = 4'd2;
        case (mod_q)
            2'd0:    k = 4'd1;
            2'd2:    k = 4'd4;
            default: k = 4'd2;
        endcase

        has_sym = ((state == RUN) || (state == FLUSH))
                && ((fill >= k) || ((state == FLUSH) && (fill != 4'd0)));
        emit    = has_sym && (!STB_O || ACK_I);
        accept  = ACK_O;
        take    = (fill >= k) ? k : fill;

        fill_after = fill - (emit ? take : 4'd0);
        acc_after  = emit ? (acc >> take) : acc;
        // Bits above the fill level are always zero, so a short flush symbol is zero-padded for free.
        acc_next   = accept ? (acc_after | (din8 << fill_after)) : acc_after;
        fill_next  = fill_after + (accept ? IN_W4 : 4'd0);
    end

    always_comb begin
        sym   = acc[3:0];
        map_i = '0;
        map_q = '0;
        case (mod_q)
            2'd0: begin
                map_i = sym[0] ? P_A : N_A;
            end
            2'd2: begin
                map_i = qam_lvl(sym[0], sym[1]);
                map_q = qam_lvl(sym[2], sym[3]);
            end
            default: begin
                map_i = sym[0] ? P_QP : N_QP;
                map_q = sym[1] ? P_QP : N_QP;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
            mod_q <= 2'd0;
            acc   <= '0;
            fill  <= '0;
            DAT_O <= '0;
            STB_O <= 1'b0;
            CYC_O <= 1'b0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;

            if (emit) begin
                DAT_O <= {map_i, map_q};
                STB_O <= 1'b1;
                CYC_O <= 1'b1;
            end else if (ACK_I) begin
                STB_O <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        mod_q <= MOD;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!CYC_I) state <= FLUSH;
                end
                FLUSH: begin
                    // fill==0 here means nothing loads this cycle, so CYC_O can drop.
                    if ((fill == 4'd0) && (!STB_O || ACK_I)) begin
                        state <= CLOSE;
                        CYC_O <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_qam_mapper.sv
// Self-checking bench for ofdm_qam_mapper: directed scenarios plus random frames
// checked against a bit-stream reference model.
module tb_ofdm_qam_mapper;

    localparam int IN_W = 2;
    localparam int IQ_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IN_W-1:0]   dat_i = '0;
    logic              cyc_i = 1'b0;
    logic              stb_i = 1'b0;
    logic              we_i = 1'b0;
    logic              ack_o;
    logic [1:0]        mod = 2'd0;
    logic [2*IQ_W-1:0] dat_o;
    logic              cyc_o;
    logic              stb_o;
    logic              we_o;
    logic              ack_i = 1'b1;
    logic [1:0]        fsm_state;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_n = 0;
    bit rand_ack = 1'b0;

    logic [2*IQ_W-1:0] exp_q[$];
    logic [2*IQ_W-1:0] obs_q[$];
    int                obs_t[$];
    bit                fbits[$];
    logic [1:0]        frame_mod = 2'd0;
    bit                frame_open = 1'b0;

    ofdm_qam_mapper #(.IN_W(IN_W), .IQ_W(IQ_W)) dut (
        .CLK_I(clk), .RST_I(rst), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i),
        .WE_I(we_i), .ACK_O(ack_o), .MOD(mod), .DAT_O(dat_o), .CYC_O(cyc_o),
        .STB_O(stb_o), .WE_O(we_o), .ACK_I(ack_i), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Capture every downstream transfer (STB_O & ACK_I at the coming edge).
    always @(negedge clk) begin
        #2;
        cyc_n++;
        if (!rst && stb_o && ack_i) begin
            obs_q.push_back(dat_o);
            obs_t.push_back(cyc_n);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    function automatic int bits_per_sym(input logic [1:0] m);
        return (m == 2'd0) ? 1 : ((m == 2'd2) ? 4 : 2);
    endfunction

    function automatic logic [2*IQ_W-1:0] ref_point(input int kk, input logic [3:0] b);
        real a;
        real u;
        int  iv;
        int  qv;
        a  = real'(1 << (IQ_W - 2));
        iv = 0;
        qv = 0;
        if (kk == 1) begin
            iv = b[0] ? int'(a) : -int'(a);
        end else if (kk == 2) begin
            u  = a / $sqrt(2.0);
            iv = int'(b[0] ? u : -u);
            qv = int'(b[1] ? u : -u);
        end else begin
            u  = a / $sqrt(10.0);
            iv = int'(u * (b[0] ? 1.0 : -1.0) * (b[1] ? 1.0 : 3.0));
            qv = int'(u * (b[2] ? 1.0 : -1.0) * (b[3] ? 1.0 : 3.0));
        end
        return {IQ_W'(iv), IQ_W'(qv)};
    endfunction

    task automatic model_accept(input logic [IN_W-1:0] d);
        if (!frame_open) begin
            frame_mod  = mod;
            frame_open = 1'b1;
        end
        for (int i = 0; i < IN_W; i++) fbits.push_back(d[i]);
    endtask

    task automatic rand_ack_drive();
        if (rand_ack) ack_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d);
        int tries;
        tries = 0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = d;
        rand_ack_drive();
        #1;
        while (!ack_o && tries < 100) begin
            @(negedge clk);
            tries++;
            rand_ack_drive();
            #1;
        end
        if (ack_o) begin
            model_accept(d);
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL beat_accept: ACK_O=%0b after %0d cycles, required 1", ack_o, tries);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        stb_i = 1'b0;
        repeat (n) begin
            rand_ack_drive();
            @(negedge clk);
        end
    endtask

    task automatic end_frame();
        int kk;
        logic [3:0] b;
        cyc_i = 1'b0; stb_i = 1'b0;
        kk = bits_per_sym(frame_mod);
        if (frame_open) begin
            for (int i = 0; i < fbits.size(); i += kk) begin
                b = '0;
                for (int j = 0; j < kk; j++)
                    if (i + j < fbits.size()) b[j] = fbits[i + j];
                exp_q.push_back(ref_point(kk, b));
            end
        end
        fbits.delete();
        frame_open = 1'b0;
        rand_ack_drive();
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        stb_i = 1'b0;
        while (obs_q.size() < exp_q.size() && t < 400) begin
            rand_ack_drive();
            @(negedge clk);
            t++;
        end
        if (obs_q.size() < exp_q.size()) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: got %0d symbols, required %0d", obs_q.size(), exp_q.size());
        end
        ack_i = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({ack_o, stb_o, cyc_o, we_o, dat_o} !== '0 || fsm_state !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: ack=%0b stb=%0b cyc=%0b we=%0b dat=%h st=%0d, required all 0",
                         c, ack_o, stb_o, cyc_o, we_o, dat_o, fsm_state);
            end
        end
        rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
        clear_sb();
    endtask

    task automatic test_qpsk();
        bit fell;
        clear_sb();
        mod = 2'd1; ack_i = 1'b1;
        send_beat(2'b01);
        stb_i = 1'b0;
        #1;
        n_cmp++;
        if (stb_o !== 1'b0) begin
            n_fail++; $display("FAIL qpsk_latency_early: STB_O=%0b one cycle after ack, required 0", stb_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (stb_o !== 1'b1 || we_o !== 1'b1 || cyc_o !== 1'b1 || dat_o !== 32'h2D41_D2BF) begin
            n_fail++;
            $display("FAIL qpsk_point: stb=%0b we=%0b cyc=%0b dat=%h, required 1 1 1 2d41d2bf",
                     stb_o, we_o, cyc_o, dat_o);
        end
        end_frame();
        fell = 1'b0;
        for (int c = 0; c < 6 && !fell; c++) begin
            #1;
            if (cyc_o === 1'b0) fell = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!fell || fsm_state !== 2'd3 || stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL qpsk_close: fell=%0b state=%0d stb=%0b, required 1 3 0", fell, fsm_state, stb_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (fsm_state !== 2'd0 || cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL qpsk_idle: state=%0d cyc=%0b, required 0 0", fsm_state, cyc_o);
        end
        @(negedge clk);
        drain();
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL qpsk_count: %0d symbols, required 1", obs_q.size());
        end
    endtask

    task automatic test_bpsk_gearbox();
        logic [31:0] want[$];
        want = '{32'hC000_0000, 32'h4000_0000};
        clear_sb();
        mod = 2'd0; ack_i = 1'b1;
        send_beat(2'b10);
        end_frame();
        drain();
        n_cmp++;
        if (obs_q.size() != want.size()) begin
            n_fail++; $display("FAIL bpsk_count: %0d symbols, required %0d", obs_q.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== want[i]) begin
                n_fail++; $display("FAIL bpsk_point[%0d]: %h, required %h", i, obs_q[i], want[i]);
            end
        end
        if (obs_t.size() >= 2) begin
            n_cmp++;
            if (obs_t[1] != obs_t[0] + 1) begin
                n_fail++; $display("FAIL bpsk_back_to_back: cycles %0d,%0d, required consecutive", obs_t[0], obs_t[1]);
            end
        end
    endtask

    task automatic test_qam_pad();
        logic [31:0] want[$];
        want = '{32'hEBC3_143D, 32'h143D_143D, 32'h143D_C349};
        clear_sb();
        mod = 2'd2; ack_i = 1'b1;
        send_beat(2'b10);
        send_beat(2'b11);
        end_frame();
        repeat (3) send_beat(2'b11);
        end_frame();
        drain();
        n_cmp++;
        if (obs_q.size() != want.size()) begin
            n_fail++; $display("FAIL qam_count: %0d symbols, required %0d", obs_q.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== want[i]) begin
                n_fail++; $display("FAIL qam_point[%0d]: %h, required %h", i, obs_q[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int acks;
        bit seen;
        bit moved;
        logic [31:0] held;
        logic [IN_W-1:0] d;
        clear_sb();
        mod = 2'd1; ack_i = 1'b0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
        acks = 0; seen = 1'b0; moved = 1'b0; held = '0;
        d = IN_W'($urandom);
        for (int c = 0; c < 10; c++) begin
            dat_i = d;
            #1;
            if (ack_o) begin
                model_accept(d);
                acks++;
                d = IN_W'($urandom);
            end
            if (stb_o) begin
                if (!seen) begin held = dat_o; seen = 1'b1; end
                else if (dat_o !== held) moved = 1'b1;
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (acks != 5 || ack_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: %0d beats acked, ACK_O=%0b, required 5 and 0", acks, ack_o);
        end
        n_cmp++;
        if (!seen || moved || stb_o !== 1'b1 || dat_o !== held) begin
            n_fail++; $display("FAIL bp_hold: seen=%0b moved=%0b stb=%0b dat=%h, required held %h", seen, moved, stb_o, dat_o, held);
        end
        ack_i = 1'b1; stb_i = 1'b0;
        repeat (2) @(negedge clk);
        end_frame();
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size() || exp_q.size() != 5) begin
            n_fail++; $display("FAIL bp_count: %0d symbols, required 5", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i] || (i > 0 && obs_t[i] != obs_t[i-1] + 1)) begin
                n_fail++; $display("FAIL bp_drain[%0d]: %h at cycle %0d, required %h one per cycle", i, obs_q[i], obs_t[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mod_change_reset();
        clear_sb();
        mod = 2'd2; ack_i = 1'b1;
        send_beat(2'b10);
        mod = 2'd0;
        send_beat(2'b11);
        send_beat(2'b01);
        send_beat(2'b00);
        end_frame();
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL modchg_count: %0d symbols, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL modchg_point[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end

        clear_sb();
        mod = 2'd2;
        send_beat(2'b11);
        rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
        fbits.delete(); frame_open = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0 || stb_o !== 1'b0 || cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_discard: %0d symbols, stb=%0b cyc=%0b, required 0 0 0", obs_q.size(), stb_o, cyc_o);
        end
        send_beat(2'b10);
        send_beat(2'b11);
        end_frame();
        drain();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'hEBC3_143D) begin
            n_fail++; $display("FAIL rst_next_frame: %0d symbols, first %h, required 1 x ebc3143d",
                               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        int nb;
        clear_sb();
        rand_ack = 1'b1;
        for (int f = 0; f < 10; f++) begin
            mod = 2'($urandom_range(0, 3));
            nb = $urandom_range(1, 9);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send_beat(IN_W'($urandom));
                if ($urandom_range(0, 2) == 0) mod = 2'($urandom_range(0, 3));
            end
            end_frame();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        drain();
        rand_ack = 1'b0;
        ack_i = 1'b1;
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: %0d symbols, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_point[%0d]: %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_qpsk();
        test_bpsk_gearbox();
        test_qam_pad();
        test_backpressure();
        test_mod_change_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_qam_mapper.md
# ofdm_qam_mapper

Parametrised successor to the fixed QPSK mapper at the head of the OFDM transmit chain, placed between the bit source and pilot insertion. Accepts IN_W-bit beats over the Wishbone-style streaming handshake and gearboxes them through an 8-bit accumulator. Emits one complex constellation point per output beat in BPSK, QPSK or 16-QAM, with Gray mapping and unit-average-power scaling. Handles frame boundaries (CYC) with zero-padding of a trailing partial symbol.

## Interface
- IN_W, 2: input bits per beat; legal values 1, 2, 4.
- IQ_W, 16: bits per I and Q component, two's complement; 1.0 = 2^(IQ_W-2).
- CLK_I  in  1  clock; all logic on rising edge.
- RST_I  in  1  reset; synchronous, active-high.
- DAT_I  in  IN_W  input bits; DAT_I[0] is the earliest bit.
- CYC_I, STB_I, WE_I  in  1 each  upstream frame / strobe / write.
- ACK_O  out  1  upstream accept, combinational.
- MOD  in  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=QPSK.
- DAT_O  out  2*IQ_W  {I, Q}, with I in the upper half.
- CYC_O, STB_O, WE_O  out  1 each  downstream frame / strobe / write.
- ACK_I  in  1  downstream accept.

## Operation
- Bits per symbol k: BPSK=1, QPSK=2, 16-QAM=4.
- MOD is latched on the first accepted beat of a frame (IDLE->RUN). Changes to MOD mid-frame are ignored.
- Accumulator: 8-bit shift register with fill count 0..8. Bits enter above the current fill and are consumed from the LSB, in arrival order (b0 first).
- Accept rule: ACK_O = CYC_I & STB_I & WE_I & (fill + IN_W <= 8) & (state is IDLE or RUN).
  - The accept rule uses the current fill only; it ignores any same-cycle consumption.
- Emit rule: the output register loads when (fill >= k, or FLUSH with fill > 0) and (!STB_O | ACK_I).
  - Same-cycle accept and emit is allowed: fill_next = fill + IN_W·accept − k·emit.
- FLUSH padding: a partial symbol is padded with zeros in the missing upper bits.
- Mapping (A = 2^(IQ_W-2); constants = round(A·c)):
  - BPSK: I = b0 ? +A : −A; Q = 0.
  - QPSK: I from b0, Q from b1; 1 maps to +A/√2, 0 maps to −A/√2. For IQ_W=16 the magnitude is 11585.
  - 16-QAM: I from (b0,b1), Q from (b2,b3). Pair 00→−3, 01→−1, 11→+1, 10→+3, in units of A/√10. For IQ_W=16, unit = 5181 and 3·unit = 15543.
- WE_O equals STB_O.
- CYC_O rises with the first STB_O of a frame. It stays high until the last symbol of the frame is acked.
- FSM:
  - IDLE: first accepted beat → RUN.
  - RUN: CYC_I low → FLUSH.
  - FLUSH: ACK_O held 0. Drain and pad. When fill = 0 and (!STB_O, or ACK_I on the last symbol) → CLOSE.
  - CLOSE: one cycle with CYC_O = 0 → IDLE.
- A CYC_I reassertion during FLUSH or CLOSE is not acked until IDLE.

## Timing
- Reset values: DAT_O=0, STB_O=0, WE_O=0, CYC_O=0, fill=0, state IDLE. ACK_O=0 while RST_I is high.
- Latency: beat acked in cycle t → fill updated at t+1 → output loaded at end of t+1 → STB_O/DAT_O valid at t+2.
- Sustained throughput: one symbol per cycle if IN_W >= k. Otherwise one symbol every k/IN_W accepted beats.
- Stall: while STB_O & !ACK_I, DAT_O and STB_O are held stable. Input continues until the accumulator is full.
- RST_I mid-frame: all state is cleared on the next edge. The partial symbol is discarded and no padding is emitted.
- A frame that ends with fill=0 and no symbols pending goes straight through FLUSH to CLOSE with no extra beat.

## Test plan
- Reset: hold RST_I 3 cycles with CYC_I/STB_I/WE_I high → ACK_O=0, STB_O=0, CYC_O=0, DAT_O=0 throughout.
- QPSK mapping, IN_W=2, MOD=1: one beat 2'b01 → two cycles later STB_O=1, DAT_O=32'h2D41_D2BF, CYC_O=1. After CYC_I drops, one CLOSE cycle with CYC_O=0.
- BPSK gearbox, IN_W=2, MOD=0: beat 2'b10 → two consecutive outputs 32'hC000_0000 then 32'h4000_0000.
- 16-QAM with padding, IN_W=2, MOD=2: beats 2'b10, 2'b11 → 32'hEBC3_143D. Next frame, beats 2'b11 ×3 → 32'h143D_143D, then the padded symbol 32'h143D_C349.
- Backpressure, QPSK, IN_W=2: ACK_I low 10 cycles, STB_I held high → exactly 5 beats acked then ACK_O=0. DAT_O stays stable. On ACK_I release, 5 symbols drain in order, one per cycle.
- Reset mid-frame, plus MOD changed mid-frame:
  - MOD toggled 2→0 mid-frame → the frame stays 16-QAM.
  - RST_I with fill=2 → no padded symbol is emitted; the next frame maps correctly from b0.
